fighter_attack_sequencer: RTL and testbench
===========================================

# fighter_attack_sequencer

Sequences one fighter's punch / crouch-punch animation in the sprite pipeline. It consumes the per-video-frame tick and player inputs, and produces the sprite-set select and frame index that drive the sprite ROM address and palette mux. It also produces the hitbox-active window used by collision logic. One instance per player. Frame timing is derived purely from `frame_tick`, so animation speed is independent of `Clk`.

## Interface
- `NUM_FRAMES`, default 4: animation frames per attack, ≥2.
- `FRAME_W`, default 2: width of `frame_idx`, equals clog2(`NUM_FRAMES`).
- `HOLD_TICKS`, default 3: frame_ticks each animation frame is displayed, ≥1.
- `ACTIVE_FIRST`, default 1: first frame index with hitbox active.
- `ACTIVE_LAST`, default 2: last frame index with hitbox active, ≥`ACTIVE_FIRST`, <`NUM_FRAMES`.
- `COOLDOWN_TICKS`, default 2: frame_ticks after an attack before new requests are accepted, ≥1.
- `Clk` in, 1 bit: system clock. One clock domain.
- `Reset_n` in, 1 bit: asynchronous active-low reset.
- `frame_tick` in, 1 bit: one-cycle pulse at vsync start.
- `attack_req` in, 1 bit: punch button, a pulse or level; sampled every cycle.
- `crouch` in, 1 bit: crouch held, as a level.
- `hit_stun` in, 1 bit: fighter was hit; aborts the attack.
- `sprite_sel` out, 2 bits: sprite set. 0 = idle, 1 = crouch, 2 = punch, 3 = crouch-punch.
- `frame_idx` out, `FRAME_W` bits: animation frame within the attack; 0 outside ATTACK.
- `hitbox_active` out, 1 bit: attack hitbox live.
- `busy` out, 1 bit: high in ATTACK or COOLDOWN.
- `done` out, 1 bit: one-cycle pulse on normal attack completion.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset.** Applies asynchronously. State = IDLE; all outputs 0; pending = 0; all counters 0.
- **Pending flag.** Set by `attack_req` on any cycle while in IDLE or CROUCH. Ignored in ATTACK and COOLDOWN; requests made there are not buffered. Cleared on entry to ATTACK and by `hit_stun`.
- **IDLE / CROUCH.** Evaluated only on `frame_tick`:
  - If pending, or `attack_req` is high this cycle: go to ATTACK. Set `frame_idx` = 0 and hold = 0. Set `sprite_sel` = 3 if `crouch` is high this cycle, else 2. This selection is latched for the whole attack.
  - Else: go to CROUCH (`sprite_sel` = 1) if `crouch` is high, else IDLE (`sprite_sel` = 0).
- **ATTACK.** On each `frame_tick`:
  - If hold < `HOLD_TICKS`−1: hold += 1.
  - Else if `frame_idx` < `NUM_FRAMES`−1: `frame_idx` += 1, hold = 0.
  - Else: go to COOLDOWN with cooldown count = 0 and `frame_idx` = 0, and pulse `done` for exactly one cycle.
- **Hitbox.** `hitbox_active` = (state == ATTACK) && `ACTIVE_FIRST` ≤ `frame_idx` ≤ `ACTIVE_LAST`.
- **COOLDOWN.** `sprite_sel` follows `crouch` (0 or 1), updated on `frame_tick`. On each `frame_tick`:
  - If count == `COOLDOWN_TICKS`−1: go to CROUCH or IDLE per `crouch`.
  - Else: count += 1.
- **Hit stun.** `hit_stun` high on any cycle, in any state, takes effect on the next edge regardless of `frame_tick`:
  - state = COOLDOWN, count = 0, `frame_idx` = 0, `hitbox_active` = 0, pending = 0.
  - `done` does not pulse.
  - `sprite_sel` = 1 if `crouch`, else 0.
- **Simultaneous events.**
  - `hit_stun` beats `frame_tick` and `attack_req`.
  - `attack_req` together with `frame_tick` in IDLE enters ATTACK at that tick.
- **Width rule.** Counters saturate-free: they never exceed their terminal value, so no wrap occurs.

## Timing
- **Start latency.** Request to ATTACK entry: the next `frame_tick` edge, plus 1 clock for registered outputs.
- **Attack length.** `NUM_FRAMES`×`HOLD_TICKS` frame_ticks (12 at defaults), counting the entry tick as the first.
- **Done pulse.** Asserted the cycle after the completing tick edge, i.e. with outputs showing COOLDOWN.
- **Hitbox window.** Asserted/deasserted with the registered `frame_idx` change. At defaults it spans ticks 3..8 after entry (6 ticks).
- **Cooldown length.** `COOLDOWN_TICKS` frame_ticks; then new requests are accepted.
- **Reset mid-attack.** All outputs drop to 0 immediately (asynchronously); no `done`.

## Test plan
- **Basic punch.** Reset, `crouch`=0, pulse `attack_req` between ticks → at next tick, `sprite_sel`=2, `frame_idx`=0. `frame_idx` steps 0→1→2→3 every 3 ticks. `hitbox_active` is high for `frame_idx` 1–2. `done` is a single 1-cycle pulse after 12 ticks. `busy` drops 2 ticks later.
- **Crouch punch latch.** `crouch`=1 at entry tick, then released mid-attack → `sprite_sel` stays 3 for all 12 ticks. `sprite_sel`=0 in COOLDOWN.
- **Requests ignored while busy.** `attack_req` pulses during ATTACK and COOLDOWN → no second attack. State returns to IDLE with `sprite_sel`=0.
- **Hit stun abort.** `hit_stun` pulse at `frame_idx`=2 → next cycle `hitbox_active`=0 and `frame_idx`=0, no `done`. IDLE is reached after 2 more ticks.
- **Simultaneous events.** `attack_req`+`hit_stun` in the same cycle → no attack, COOLDOWN. `attack_req`+`frame_tick` in IDLE → ATTACK on that tick.
- **Async reset mid-attack.** Deassert `Reset_n` between clock edges at `frame_idx`=1 → outputs 0 before the next edge. After release, the next request starts at `frame_idx`=0.

Source files
------------

// File: rtl/fighter_attack_sequencer.sv
// ============================================================================
// Module      : fighter_attack_sequencer
// Description : Per-player punch / crouch-punch animation sequencer driving
//               sprite set, frame index, hitbox window and busy/done flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fighter_attack_sequencer #(
    parameter int NUM_FRAMES     = 4,
    parameter int FRAME_W        = 2,
    parameter int HOLD_TICKS     = 3,
    parameter int ACTIVE_FIRST   = 1,
    parameter int ACTIVE_LAST    = 2,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               attack_req,
    input  logic               crouch,
    input  logic               hit_stun,
    output logic [1:0]         sprite_sel,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               hitbox_active,
    output logic               busy,
    output logic               done
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int CD_W   = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CROUCH   = 2'd1;
    localparam logic [1:0] ST_ATTACK   = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    localparam logic [1:0] SEL_PUNCH        = 2'd2;
    localparam logic [1:0] SEL_CROUCH_PUNCH = 2'd3;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] ACT_FIRST  = FRAME_W'(ACTIVE_FIRST);
    localparam logic [FRAME_W-1:0] ACT_LAST   = FRAME_W'(ACTIVE_LAST);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COOLDOWN_TICKS - 1);

    logic [1:0]         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CD_W-1:0]    cd_cnt;
    logic               pending;

    logic [1:0]         state_nx;
    logic [HOLD_W-1:0]  hold_nx;
    logic [CD_W-1:0]    cd_nx;
    logic               pending_nx;
    logic [1:0]         sel_nx;
    logic [FRAME_W-1:0] frame_nx;
    logic               done_nx;
    logic               hitbox_nx;
    logic               busy_nx;

    // Rest pose (idle or crouch) as both a state and its sprite set.
    logic [1:0]         rest_sel;
    assign rest_sel = {1'b0, crouch};

    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        cd_nx      = cd_cnt;
        pending_nx = pending;
        sel_nx     = sprite_sel;
        frame_nx   = frame_idx;
        done_nx    = 1'b0;

        if (hit_stun) begin
            state_nx   = ST_COOLDOWN;
            cd_nx      = '0;
            hold_nx    = '0;
            frame_nx   = '0;
            pending_nx = 1'b0;
            sel_nx     = rest_sel;
        end else begin
            case (state)
                ST_IDLE, ST_CROUCH: begin
                    if (attack_req) begin
                        pending_nx = 1'b1;
                    end
                    if (frame_tick) begin
                        if (pending || attack_req) begin
                            state_nx   = ST_ATTACK;
                            frame_nx   = '0;
                            hold_nx    = '0;
                            pending_nx = 1'b0;
                            sel_nx     = crouch ? SEL_CROUCH_PUNCH : SEL_PUNCH;
                        end else begin
                            state_nx = rest_sel;
                            sel_nx   = rest_sel;
                        end
                    end
                end
                ST_ATTACK: begin
                    if (frame_tick) begin
                        if (hold_cnt != HOLD_LAST) begin
                            hold_nx = hold_cnt + 1'b1;
                        end else if (frame_idx != FRAME_LAST) begin
                            frame_nx = frame_idx + 1'b1;
                            hold_nx  = '0;
                        end else begin
                            state_nx = ST_COOLDOWN;
                            cd_nx    = '0;
                            hold_nx  = '0;
                            frame_nx = '0;
                            sel_nx   = rest_sel;
                            done_nx  = 1'b1;
                        end
                    end
                end
                default: begin
                    if (frame_tick) begin
                        sel_nx = rest_sel;
                        if (cd_cnt == CD_LAST) begin
                            state_nx = rest_sel;
                            cd_nx    = '0;
                        end else begin
                            cd_nx = cd_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end

        // Registered flags are derived from the next state so they line up with frame_idx.
        hitbox_nx = (state_nx == ST_ATTACK) && (frame_nx >= ACT_FIRST) && (frame_nx <= ACT_LAST);
        busy_nx   = (state_nx == ST_ATTACK) || (state_nx == ST_COOLDOWN);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            cd_cnt        <= '0;
            pending       <= 1'b0;
            sprite_sel    <= 2'd0;
            frame_idx     <= '0;
            hitbox_active <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            hold_cnt      <= hold_nx;
            cd_cnt        <= cd_nx;
            pending       <= pending_nx;
            sprite_sel    <= sel_nx;
            frame_idx     <= frame_nx;
            hitbox_active <= hitbox_nx;
            busy          <= busy_nx;
            done          <= done_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fighter_attack_sequencer.sv
// ============================================================================
// Module      : tb_fighter_attack_sequencer
// Description : Randomized self-checking bench for fighter_attack_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fighter_attack_sequencer;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int HT = 3;
    localparam int AF = 1;
    localparam int AL = 2;
    localparam int CT = 2;

    logic          Clk        = 1'b0;
    logic          Reset_n    = 1'b0;
    logic          frame_tick = 1'b0;
    logic          attack_req = 1'b0;
    logic          crouch     = 1'b0;
    logic          hit_stun   = 1'b0;
    logic [1:0]    sprite_sel;
    logic [FW-1:0] frame_idx;
    logic          hitbox_active;
    logic          busy;
    logic          done;

    fighter_attack_sequencer #(
        .NUM_FRAMES(NF), .FRAME_W(FW), .HOLD_TICKS(HT),
        .ACTIVE_FIRST(AF), .ACTIVE_LAST(AL), .COOLDOWN_TICKS(CT)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .attack_req(attack_req), .crouch(crouch), .hit_stun(hit_stun),
        .sprite_sel(sprite_sel), .frame_idx(frame_idx),
        .hitbox_active(hitbox_active), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: phase 0=rest, 1=attack, 2=cooldown; attack tracked as ticks elapsed since entry.
    int m_phase;
    int m_elapsed;
    int m_cd;
    bit m_pend;
    int m_sel;
    bit m_done;

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_cd = 0; m_pend = 0; m_sel = 0; m_done = 0;
    endtask

    task automatic model_step(input bit tk, input bit rq, input bit cr, input bit st);
        m_done = 0;
        if (st) begin
            m_phase = 2; m_cd = 0; m_pend = 0; m_sel = cr; m_elapsed = 0;
        end else if (m_phase == 0) begin
            if (tk) begin
                if (m_pend || rq) begin
                    m_phase = 1; m_elapsed = 0; m_pend = 0; m_sel = cr ? 3 : 2;
                end else begin
                    m_sel = cr;
                end
            end else if (rq) begin
                m_pend = 1;
            end
        end else if (m_phase == 1) begin
            if (tk) begin
                m_elapsed++;
                if (m_elapsed == NF * HT) begin
                    m_phase = 2; m_cd = 0; m_elapsed = 0; m_done = 1; m_sel = cr;
                end
            end
        end else begin
            if (tk) begin
                m_sel = cr;
                m_cd++;
                if (m_cd == CT) begin
                    m_phase = 0; m_cd = 0;
                end
            end
        end
    endtask

    function automatic int exp_frame();
        return (m_phase == 1) ? (m_elapsed / HT) : 0;
    endfunction

    task automatic check_all(input string ctx);
        int f;
        f = exp_frame();
        check({ctx, ".sprite_sel"}, 32'(sprite_sel), 32'(m_sel));
        check({ctx, ".frame_idx"}, 32'(frame_idx), 32'(f));
        check({ctx, ".hitbox"}, 32'(hitbox_active), 32'((m_phase == 1) && f >= AF && f <= AL));
        check({ctx, ".busy"}, 32'(busy), 32'(m_phase != 0));
        check({ctx, ".done"}, 32'(done), 32'(m_done));
    endtask

    initial begin
        int gap;
        int next_reset;
        bit tk, rq, st;
        gap = 0;
        next_reset = 200;
        model_reset();
        #12;
        check_all("reset");
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc > next_reset && m_phase == 1 && exp_frame() == 1) begin
                next_reset = cyc + 1500;
                Reset_n = 1'b0;
                #2;
                model_reset();
                check_all("async_reset");
                @(posedge Clk);
                #1;
                check_all("reset_hold");
                Reset_n = 1'b1;
            end

            if (gap == 0) begin
                tk  = 1'b1;
                gap = $urandom_range(0, 3);
            end else begin
                tk = 1'b0;
                gap--;
            end
            rq = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) crouch = ~crouch;
            frame_tick = tk;
            attack_req = rq;
            hit_stun   = st;

            @(posedge Clk);
            model_step(tk, rq, crouch, st);
            #1;
            check_all("run");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
